// File: rtl/lcd_1602a_pkg.sv
// Shared definitions for the 1602A read and write drivers: FSM states,
// control-bit positions in the {RS,RW,EN} vector and 20 MHz timing defaults.
package lcd_1602a_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHI,
    ELO,
    CHECK,
    DONE
  } lcd_state_e;

  localparam int CTRL_RS = 2;
  localparam int CTRL_RW = 1;
  localparam int CTRL_EN = 0;

  // Parked control pattern: RW=1 so the panel never sees a write strobe.
  localparam logic [2:0] CTRL_IDLE = 3'b010;

  localparam int LCD_CNT_W    = 8;
  localparam int LCD_T_AS_CYC = 1;
  localparam int LCD_T_EH_CYC = 5;
  localparam int LCD_T_EL_CYC = 5;
  localparam int LCD_POLL_MAX = 1000;

endpackage

// File: rtl/lcd_1602a_reader_if.sv
// Host request/response and LCD pin bundle for the 1602A reader.
// slave: the reader itself; master: the host plus the LCD pad model.
interface lcd_1602a_reader_if;

  logic       rd_req;
  logic       rd_rs;
  logic       rd_poll;
  logic [3:0] lcd_d_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       bus_own;
  logic       rd_rdy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_err;

  modport slave (
    input  rd_req, rd_rs, rd_poll, lcd_d_in,
    output lcd_rs, lcd_rw, lcd_e, bus_own, rd_rdy, rd_data, rd_valid, rd_err
  );

  modport master (
    output rd_req, rd_rs, rd_poll, lcd_d_in,
    input  lcd_rs, lcd_rw, lcd_e, bus_own, rd_rdy, rd_data, rd_valid, rd_err
  );

endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used as the phase timer of the 1602A drivers.
// A load of N gives N+1 cycles in the current phase before o_done is seen.
module lcd_delay_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_1602a_reader.sv
// HD44780/1602A 4-bit read engine: busy-flag/AC or data reads with optional BF polling.
// LCD_RD_TIMEOUT_EN enables the POLL_MAX read limit and rd_err; otherwise polling is unbounded.
module lcd_1602a_reader
  import lcd_1602a_pkg::*;
#(
  parameter int T_AS_CYC = LCD_T_AS_CYC,
  parameter int T_EH_CYC = LCD_T_EH_CYC,
  parameter int T_EL_CYC = LCD_T_EL_CYC
`ifdef LCD_RD_TIMEOUT_EN
  ,
  parameter int POLL_MAX = LCD_POLL_MAX
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_1602a_reader_if.slave    bus
);

  localparam logic [LCD_CNT_W-1:0] L_AS = LCD_CNT_W'(T_AS_CYC - 1);
  localparam logic [LCD_CNT_W-1:0] L_EH = LCD_CNT_W'(T_EH_CYC - 1);
  localparam logic [LCD_CNT_W-1:0] L_EL = LCD_CNT_W'(T_EL_CYC - 1);

  lcd_state_e     r_state;
  logic [2:0]     r_ctrl;
  logic           r_rs;
  logic           r_poll;
  logic           r_nibble;
  logic [7:0]     r_shadow;
  logic [7:0]     r_data;
  logic           r_valid;
  logic           r_rdy;
  logic           r_busOwn;

  logic                 w_load;
  logic [LCD_CNT_W-1:0] w_loadVal;
  logic                 w_done;
  logic                 w_pollAgain;

`ifdef LCD_RD_TIMEOUT_EN
  localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PCW-1:0] L_PMAX = PCW'(POLL_MAX - 1);

  logic [PCW-1:0] r_pollCnt;
  logic           r_err;
  logic           w_busy;

  assign w_busy      = !r_rs && r_poll && r_shadow[7];
  assign w_pollAgain = w_busy && (r_pollCnt < L_PMAX);
`else
  assign w_pollAgain = !r_rs && r_poll && r_shadow[7];
`endif

  lcd_delay_cnt #(.WIDTH(LCD_CNT_W)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_loadVal),
    .o_done  (w_done)
  );

  // The timer is reloaded on the very edge that moves the FSM into a timed phase.
  always_comb begin
    w_load    = 1'b0;
    w_loadVal = '0;
    case (r_state)
      IDLE:  if (bus.rd_req)              begin w_load = 1'b1; w_loadVal = L_AS; end
      SETUP: if (w_done)                  begin w_load = 1'b1; w_loadVal = L_EH; end
      EHI:   if (w_done)                  begin w_load = 1'b1; w_loadVal = L_EL; end
      ELO:   if (w_done && !r_nibble)     begin w_load = 1'b1; w_loadVal = L_EH; end
      CHECK: if (w_pollAgain)             begin w_load = 1'b1; w_loadVal = L_EH; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ctrl   <= CTRL_IDLE;
      r_rs     <= 1'b0;
      r_poll   <= 1'b0;
      r_nibble <= 1'b0;
      r_shadow <= 8'h00;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_rdy    <= 1'b1;
      r_busOwn <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
      r_pollCnt <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rd_req) begin
            r_rs             <= bus.rd_rs;
            r_poll           <= bus.rd_poll;
            r_nibble         <= 1'b0;
            r_rdy            <= 1'b0;
            r_busOwn         <= 1'b1;
            r_ctrl           <= CTRL_IDLE;
            r_ctrl[CTRL_RS]  <= bus.rd_rs;
`ifdef LCD_RD_TIMEOUT_EN
            r_pollCnt <= '0;
            r_err     <= 1'b0;
`endif
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_done) begin
            r_ctrl[CTRL_EN] <= 1'b1;
            r_state         <= EHI;
          end
        end
        EHI: begin
          if (w_done) begin
            if (!r_nibble) r_shadow[7:4] <= bus.lcd_d_in;
            else           r_shadow[3:0] <= bus.lcd_d_in;
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= ELO;
          end
        end
        ELO: begin
          if (w_done) begin
            r_nibble <= ~r_nibble;
            if (!r_nibble) begin
              r_ctrl[CTRL_EN] <= 1'b1;
              r_state         <= EHI;
            end else begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_pollAgain) begin
`ifdef LCD_RD_TIMEOUT_EN
            r_pollCnt <= r_pollCnt + 1'b1;
`endif
            r_ctrl[CTRL_EN] <= 1'b1;
            r_state         <= EHI;
          end else begin
            // Result is registered on entry to DONE so rd_valid is high during DONE.
            r_data   <= r_shadow;
            r_valid  <= 1'b1;
            r_busOwn <= 1'b0;
            r_ctrl   <= CTRL_IDLE;
`ifdef LCD_RD_TIMEOUT_EN
            r_err    <= w_busy;
`endif
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.lcd_rs   = r_ctrl[CTRL_RS];
  assign bus.lcd_rw   = r_ctrl[CTRL_RW];
  assign bus.lcd_e    = r_ctrl[CTRL_EN];
  assign bus.bus_own  = r_busOwn;
  assign bus.rd_rdy   = r_rdy;
  assign bus.rd_data  = r_data;
  assign bus.rd_valid = r_valid;
`ifdef LCD_RD_TIMEOUT_EN
  assign bus.rd_err   = r_err;
`else
  assign bus.rd_err   = 1'b0;
`endif

endmodule
